// File: rtl/clock_period_meter.sv
// Measures the period of a slow asynchronous clock in clk cycles, declares lock and flags loss of signal.
// Optional high-phase measurement (highTime port) is built when DUTY_MEASURE_EN is defined.
module clock_period_meter #(
  parameter int unsigned MAX_PERIOD = 50000000,
  parameter int unsigned TOLERANCE  = 2,
  parameter int unsigned LOCK_COUNT = 4,
  localparam int PW = $clog2(MAX_PERIOD + 1),
  localparam int MW = $clog2(LOCK_COUNT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          slowClk,
  output logic          edgeTick,
  output logic [PW-1:0] period,
  output logic          periodValid,
  output logic          locked,
  output logic          timeout
`ifdef DUTY_MEASURE_EN
  ,
  output logic [PW-1:0] highTime
`endif
);

  localparam logic [PW-1:0] MAX_P  = PW'(MAX_PERIOD);
  localparam logic [PW-1:0] TOL_P  = PW'(TOLERANCE);
  localparam logic [MW-1:0] LOCK_P = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;

  state_t        state_q, state_d;
  logic          s1_q, s2_q, s3_q;
  logic [1:0]    fill_q, fill_d;
  logic          armed_q, armed_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] period_q, period_d;
  logic          pv_q, pv_d;
  logic          to_q, to_d;
  logic          locked_q, locked_d;
  logic          have_prev_q, have_prev_d;
  logic [MW-1:0] match_q, match_d;
  logic [MW-1:0] match_nx;
  logic [PW-1:0] diff;
  logic          is_match;
  logic          at_max;
`ifdef DUTY_MEASURE_EN
  logic [PW-1:0] hi_q, hi_d;
  logic [PW-1:0] high_q, high_d;
`endif

  function automatic logic [PW-1:0] sat_inc(input logic [PW-1:0] v);
    return (v >= MAX_P) ? MAX_P : v + 1'b1;
  endfunction

  // An edge is only accepted once the synchroniser has shown a real low sample,
  // so a slowClk that is already high when reset releases does not count.
  always_comb begin
    fill_d  = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
    armed_d = armed_q | ((fill_q == 2'd2) & ~s2_q);
  end

  assign edgeTick = s2_q & ~s3_q & armed_q;

  always_comb begin
    cnt_d    = edgeTick ? PW'(1) : sat_inc(cnt_q);
    at_max   = (cnt_q == MAX_P);
    diff     = (cnt_q >= period_q) ? (cnt_q - period_q) : (period_q - cnt_q);
    is_match = have_prev_q && (diff <= TOL_P);
    match_nx = (match_q >= LOCK_P) ? LOCK_P : match_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      fill_q      <= 2'd0;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      period_q    <= '0;
      pv_q        <= 1'b0;
      to_q        <= 1'b0;
      locked_q    <= 1'b0;
      have_prev_q <= 1'b0;
      match_q     <= '0;
`ifdef DUTY_MEASURE_EN
      hi_q        <= '0;
      high_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      s1_q        <= slowClk;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      fill_q      <= fill_d;
      armed_q     <= armed_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      pv_q        <= pv_d;
      to_q        <= to_d;
      locked_q    <= locked_d;
      have_prev_q <= have_prev_d;
      match_q     <= match_d;
`ifdef DUTY_MEASURE_EN
      hi_q        <= hi_d;
      high_q      <= high_d;
`endif
    end
  end

  // Edge wins over the saturation timeout when both occur in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (edgeTick) state_d = MEASURE;
      MEASURE: begin
        if (edgeTick) begin
          if (is_match && (match_nx == LOCK_P)) state_d = LOCKED;
        end else if (at_max) begin
          state_d = IDLE;
        end
      end
      LOCKED:  begin
        if (edgeTick) begin
          if (!is_match) state_d = MEASURE;
        end else if (at_max) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    period_d    = period_q;
    pv_d        = 1'b0;
    to_d        = 1'b0;
    have_prev_d = have_prev_q;
    match_d     = match_q;
`ifdef DUTY_MEASURE_EN
    hi_d        = edgeTick ? PW'(1) : (s2_q ? sat_inc(hi_q) : hi_q);
    high_d      = high_q;
`endif
    case (state_q)
      IDLE: begin
        if (edgeTick) begin
          have_prev_d = 1'b0;
          match_d     = '0;
        end
      end
      MEASURE, LOCKED: begin
        if (edgeTick) begin
          period_d    = cnt_q;
          pv_d        = 1'b1;
          have_prev_d = 1'b1;
          match_d     = is_match ? match_nx : '0;
`ifdef DUTY_MEASURE_EN
          high_d      = hi_q;
`endif
        end else if (at_max) begin
          to_d        = 1'b1;
          period_d    = '0;
          have_prev_d = 1'b0;
          match_d     = '0;
`ifdef DUTY_MEASURE_EN
          high_d      = '0;
`endif
        end
      end
      default: ;
    endcase
    locked_d = (state_d == LOCKED);
  end

  assign period      = period_q;
  assign periodValid = pv_q;
  assign timeout     = to_q;
  assign locked      = locked_q;
`ifdef DUTY_MEASURE_EN
  assign highTime    = high_q;
`endif

endmodule
